lbp_win: RTL and testbench

Parametrised local-binary-pattern engine; successor to the fixed 128×128 LBP block. It reads a grayscale image of configurable size and pixel width from the host gray memory. It writes one 8-bit LBP code per interior pixel to the LBP memory. A 3×3 sliding window register is reused along each row, so only the new right-hand column (3 reads) is fetched per pixel after the first window of a row.

---
 rtl/lbp_win.sv | 206 ++++++++++++++++++++
 tb/tb_lbp_win.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lbp_win.sv
// -----------------------------------------------------------------------------
// lbp_win -- parametrised local-binary-pattern engine.
//
// Reads an IMG_W x IMG_H grayscale image (PW-bit pixels) from a host memory
// and writes one 8-bit LBP code for every interior pixel, in raster order.
// A 3x3 window register slides along each row. The first window of a row
// costs 9 reads (column-major). Every later window costs 3 reads, because
// only the new right-hand column is fetched.
//
// Optional feature macro: LBP_THRESH_EN
//   When defined, the i_lbp_thresh port exists.
//   A code bit is then set iff n >= c + i_lbp_thresh.
//   When undefined, the engine behaves as if the threshold were 0.
//
// Ports:
//   i_clk         clock, all logic on the rising edge
//   i_reset       synchronous, active-high reset
//   i_gray_ready  host image ready, sampled only while idle
//   i_gray_data   pixel at o_gray_addr, valid in the same cycle
//   i_lbp_thresh  compare offset (LBP_THRESH_EN only)
//   o_gray_addr   raster address (y*IMG_W + x) of the requested pixel
//   o_gray_req    high in cycles that issue a read
//   o_lbp_addr    raster address of the code being written
//   o_lbp_valid   one-cycle write strobe for o_lbp_addr/o_lbp_data
//   o_lbp_data    LBP code
//   o_finish      image complete, sticky until reset
// -----------------------------------------------------------------------------
module lbp_win #(
   parameter int IMG_W = 128,
   parameter int IMG_H = 128,
   parameter int PW    = 8,
   parameter int AW    = 14
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_gray_ready,
   input  logic [PW-1:0] i_gray_data,
`ifdef LBP_THRESH_EN
   input  logic [PW-1:0] i_lbp_thresh,
`endif
   output logic [AW-1:0] o_gray_addr,
   output logic          o_gray_req,
   output logic [AW-1:0] o_lbp_addr,
   output logic          o_lbp_valid,
   output logic [7:0]    o_lbp_data,
   output logic          o_finish
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

   localparam logic [AW-1:0] X_LAST = AW'(IMG_W - 2);
   localparam logic [AW-1:0] Y_LAST = AW'(IMG_H - 2);
   localparam logic [AW-1:0] W_AW   = AW'(IMG_W);
   localparam logic [AW-1:0] ONE    = AW'(1);

   state_t        r_state, w_next;
   logic [AW-1:0] r_x, r_y;          // centre of the current window
   logic [1:0]    r_row, r_col;      // read position inside the window
   logic [PW-1:0] r_win [3][3];      // [row][col]
   logic          r_lbp_valid, r_finish;
   logic [AW-1:0] r_lbp_addr;
   logic [7:0]    r_lbp_data;

   logic          w_req, w_last;
   logic [1:0]    w_col;
   logic [AW-1:0] w_rd_x, w_rd_y, w_c_addr;
   logic [PW-1:0] w_thr;
   logic [PW:0]   w_ref;
   logic [PW-1:0] w_nb [8];
   logic [7:0]    w_code;

`ifdef LBP_THRESH_EN
   assign w_thr = i_lbp_thresh;
`else
   assign w_thr = '0;
`endif

   // Read address generation and LBP compare.
   // NOTE: every signal is given a default first, so no latch can be inferred.
   always_comb begin
      w_req  = (r_state == S_LOAD) || (r_state == S_SHIFT);
      // SHIFT fetches only the right-hand column.
      w_col  = (r_state == S_SHIFT) ? 2'd2 : r_col;
      w_rd_x = r_x + AW'(w_col) - ONE;
      w_rd_y = r_y + AW'(r_row) - ONE;
      w_last = w_req && (r_row == 2'd2) && (w_col == 2'd2);
      w_c_addr = r_y * W_AW + r_x;

      // The last read of every window is the bottom-right pixel.
      // That pixel is still on i_gray_data, so it is used directly here.
      w_nb[0] = r_win[0][0];
      w_nb[1] = r_win[0][1];
      w_nb[2] = r_win[0][2];
      w_nb[3] = r_win[1][0];
      w_nb[4] = r_win[1][2];
      w_nb[5] = r_win[2][0];
      w_nb[6] = r_win[2][1];
      w_nb[7] = i_gray_data;

      // The sum is one bit wider than a pixel.
      // If c + thresh overflows PW bits, no neighbour can reach it,
      // so every code bit is 0.
      w_ref = {1'b0, r_win[1][1]} + {1'b0, w_thr};
      w_code = '0;
      for (int i = 0; i < 8; i++) begin
         w_code[i] = ({1'b0, w_nb[i]} >= w_ref);
      end
   end

   assign o_gray_req  = w_req;
   assign o_gray_addr = w_req ? (w_rd_y * W_AW + w_rd_x) : '0;
   assign o_lbp_addr  = r_lbp_addr;
   assign o_lbp_valid = r_lbp_valid;
   assign o_lbp_data  = r_lbp_data;
   assign o_finish    = r_finish;

   // State register.
   // NOTE: sequential state uses non-blocking assignments.
   // As a result, every flop samples values from before the edge.
   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   // Next-state logic.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (i_gray_ready) w_next = S_LOAD;
         S_LOAD, S_SHIFT: begin
            if (w_last) begin
               if      (r_x < X_LAST) w_next = S_SHIFT;
               else if (r_y < Y_LAST) w_next = S_LOAD;
               else                   w_next = S_DONE;
            end
         end
         S_DONE:  w_next = S_DONE;
         default: w_next = S_IDLE;
      endcase
   end

   // Scan position, code output and finish flag.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_x         <= ONE;
         r_y         <= ONE;
         r_row       <= '0;
         r_col       <= '0;
         r_lbp_valid <= 1'b0;
         r_lbp_addr  <= '0;
         r_lbp_data  <= '0;
         r_finish    <= 1'b0;
      end else begin
         r_lbp_valid <= w_last;
         if (r_state == S_IDLE) begin
            r_x   <= ONE;
            r_y   <= ONE;
            r_row <= '0;
            r_col <= '0;
         end else if (w_last) begin
            r_row      <= '0;
            r_col      <= '0;
            r_lbp_addr <= w_c_addr;
            r_lbp_data <= w_code;
            if (r_x < X_LAST) begin
               r_x <= r_x + ONE;
            end else if (r_y < Y_LAST) begin
               r_x <= ONE;
               r_y <= r_y + ONE;
            end else begin
               r_finish <= 1'b1;
            end
         end else if (w_req) begin
            // Column-major: walk down the rows, then step to the next column.
            if (r_row == 2'd2) begin
               r_row <= '0;
               r_col <= r_col + 2'd1;
            end else begin
               r_row <= r_row + 2'd1;
            end
         end
      end
   end

   // Window register.
   // NOTE: the window has no reset. Every window is fully rewritten
   // before its code is used, so stale contents never reach an output.
   always_ff @(posedge i_clk) begin
      if (r_state == S_LOAD) begin
         r_win[r_row][r_col] <= i_gray_data;
      end else if (r_state == S_SHIFT) begin
         if (r_row == 2'd0) begin
            // The first read of a SHIFT window also moves the window
            // one column to the left.
            for (int r = 0; r < 3; r++) begin
               r_win[r][0] <= r_win[r][1];
               r_win[r][1] <= r_win[r][2];
            end
            r_win[0][2] <= i_gray_data;
         end else begin
            r_win[r_row][2] <= i_gray_data;
         end
      end
   end

endmodule

// File: tb/tb_lbp_win.sv
// -----------------------------------------------------------------------------
// tb_lbp_win -- scoreboard bench for lbp_win.
// A 4x4 instance covers the hand-computed directed images.
// A 128x128 instance covers the full default run and a reset that arrives
// mid-row. Expected writes and read addresses are queued by the stimulus.
// Monitors pop and compare them whenever the DUT strobes.
// -----------------------------------------------------------------------------
module tb_lbp_win;

   typedef struct {
      int addr;
      int data;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;
   logic rdy_s, rdy_l;
   int   mode;

   logic [3:0]  s_gaddr, s_laddr;
   logic        s_req, s_valid, s_fin;
   logic [7:0]  s_gdata, s_ldata;
   logic [13:0] l_gaddr, l_laddr;
   logic        l_req, l_valid, l_fin;
   logic [7:0]  l_gdata, l_ldata;
`ifdef LBP_THRESH_EN
   logic [7:0]  thr;
`endif

   exp_t q_s[$];
   exp_t q_l[$];
   int   q_rd[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   rd_s = 0, rd_l = 0, wr_l = 0;

   // Small test images, selected by mode.
   function automatic logic [7:0] pix_small(int m, logic [3:0] a);
      case (m)
         0:       return 8'd50;
         1:       return {4'd0, a};
         2:       return (a == 4'd1 || a == 4'd14) ? 8'd5 : 8'd10;
         default: return 8'd255;
      endcase
   endfunction

   always_comb s_gdata = pix_small(mode, s_gaddr);
   // In the large image every pixel equals its row index.
   always_comb l_gdata = {1'b0, l_gaddr[13:7]};

   lbp_win #(.IMG_W(4), .IMG_H(4), .PW(8), .AW(4)) u_small (
      .i_clk        (clk),
      .i_reset      (reset),
      .i_gray_ready (rdy_s),
      .i_gray_data  (s_gdata),
`ifdef LBP_THRESH_EN
      .i_lbp_thresh (thr),
`endif
      .o_gray_addr  (s_gaddr),
      .o_gray_req   (s_req),
      .o_lbp_addr   (s_laddr),
      .o_lbp_valid  (s_valid),
      .o_lbp_data   (s_ldata),
      .o_finish     (s_fin)
   );

   lbp_win #(.IMG_W(128), .IMG_H(128), .PW(8), .AW(14)) u_large (
      .i_clk        (clk),
      .i_reset      (reset),
      .i_gray_ready (rdy_l),
      .i_gray_data  (l_gdata),
`ifdef LBP_THRESH_EN
      .i_lbp_thresh (8'd0),
`endif
      .o_gray_addr  (l_gaddr),
      .o_gray_req   (l_req),
      .o_lbp_addr   (l_laddr),
      .o_lbp_valid  (l_valid),
      .o_lbp_data   (l_ldata),
      .o_finish     (l_fin)
   );

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                  name, act, act, exp, exp, $time);
      end
   endtask

   task automatic fail_now(input string name, input longint act);
      n_checks++;
      n_fail++;
      $display("FAIL %s: got %0d, nothing expected at %0t", name, act, $time);
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      cyc(1);
      reset = 1'b0;
   endtask

   // Small-DUT monitor: read addresses and code writes.
   always @(negedge clk) begin
      if (s_req) begin
         rd_s++;
         if (q_rd.size() == 0) fail_now("s_read_unexpected", s_gaddr);
         else check("s_read_addr", s_gaddr, q_rd.pop_front());
      end
      if (s_valid) begin
         if (q_s.size() == 0) begin
            fail_now("s_write_unexpected", s_laddr);
         end else begin
            exp_t e;
            e = q_s.pop_front();
            check("s_lbp_addr", s_laddr, e.addr);
            check("s_lbp_data", s_ldata, e.data);
            check("s_finish_with_write", s_fin, (e.addr == 10) ? 1 : 0);
            if (e.addr == 10) check("s_req_after_last", s_req, 0);
         end
      end
   end

   // Large-DUT monitor: code writes only. Reads are counted.
   always @(negedge clk) begin
      if (l_req) rd_l++;
      if (l_valid) begin
         wr_l++;
         if (q_l.size() == 0) begin
            fail_now("l_write_unexpected", l_laddr);
         end else begin
            exp_t e;
            e = q_l.pop_front();
            check("l_lbp_addr", l_laddr, e.addr);
            check("l_lbp_data", l_ldata, e.data);
            check("l_finish_with_write", l_fin, (e.addr == 16254) ? 1 : 0);
            if (e.addr == 16254) check("l_req_after_last", l_req, 0);
         end
      end
   end

   // One full 4x4 run. The four expected codes are at 5, 6, 9 and 10.
   task automatic run_small(input int m, input int e0, input int e1,
                            input int e2, input int e3);
      int codes[4];
      int addrs[4];
      codes = '{e0, e1, e2, e3};
      addrs = '{5, 6, 9, 10};
      mode = m;
      rd_s = 0;
      for (int y = 1; y <= 2; y++) begin
         for (int c = 0; c < 3; c++)
            for (int r = 0; r < 3; r++) q_rd.push_back((y - 1 + r) * 4 + c);
         for (int r = 0; r < 3; r++) q_rd.push_back((y - 1 + r) * 4 + 3);
      end
      for (int i = 0; i < 4; i++) q_s.push_back('{addr: addrs[i], data: codes[i]});
      rdy_s = 1'b1;
      cyc(1);
      rdy_s = 1'b0;
      for (int k = 0; k < 100 && !s_fin; k++) @(negedge clk);
      if (!s_fin) fail_now("s_finish_timeout", s_fin);
      cyc(5);
      @(negedge clk);
      check("s_finish_sticky", s_fin, 1);
      check("s_req_in_done", s_req, 0);
      check("s_read_count", rd_s, 24);
      check("s_pending_writes", q_s.size(), 0);
      check("s_pending_reads", q_rd.size(), 0);
      q_s.delete();
      q_rd.delete();
      cyc(1);
      pulse_reset();
      @(negedge clk);
      check("s_finish_cleared", s_fin, 0);
      cyc(1);
   endtask

   initial begin
      reset = 1'b1;
      rdy_s = 1'b0;
      rdy_l = 1'b0;
      mode  = 0;
`ifdef LBP_THRESH_EN
      thr   = 8'd0;
`endif
      cyc(3);
      @(negedge clk);
      check("rst_small_outs", {s_req, s_valid, s_fin, s_gaddr, s_laddr, s_ldata}, 0);
      check("rst_large_outs", {l_req, l_valid, l_fin, l_gaddr, l_laddr, l_ldata}, 0);
      cyc(1);
      reset = 1'b0;

      // Idle with gray_ready low: no activity.
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("idle_outs", {s_req, s_valid, s_fin, s_gaddr}, 0);
      end
      cyc(1);

      run_small(0, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
      run_small(1, 8'hF0, 8'hF0, 8'hF0, 8'hF0);
      run_small(2, 8'hFD, 8'hFE, 8'h7F, 8'hBF);
`ifdef LBP_THRESH_EN
      thr = 8'd2;
      run_small(1, 8'hE0, 8'hE0, 8'hE0, 8'hE0);
      thr = 8'd1;
      run_small(3, 8'h00, 8'h00, 8'h00, 8'h00);
      thr = 8'd0;
`endif

      // Large run, aborted by reset during the SHIFT of the second window.
      rd_l = 0;
      q_l.push_back('{addr: 129, data: 8'hF8});
      rdy_l = 1'b1;
      cyc(1);
      rdy_l = 1'b0;
      for (int k = 0; k < 200 && rd_l < 11; k++) @(negedge clk);
      if (rd_l < 11) fail_now("l_shift_timeout", rd_l);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("l_reset_midrow_outs", {l_req, l_valid, l_fin, l_gaddr, l_laddr, l_ldata}, 0);
      check("l_aborted_writes", q_l.size(), 0);
      q_l.delete();
      cyc(2);

      // Full default run.
      rd_l = 0;
      wr_l = 0;
      for (int y = 1; y <= 126; y++)
         for (int x = 1; x <= 126; x++)
            q_l.push_back('{addr: y * 128 + x, data: 8'hF8});
      rdy_l = 1'b1;
      cyc(1);
      rdy_l = 1'b0;
      for (int k = 0; k < 60000 && !l_fin; k++) @(negedge clk);
      if (!l_fin) fail_now("l_finish_timeout", l_fin);
      cyc(10);
      @(negedge clk);
      check("l_finish_sticky", l_fin, 1);
      check("l_read_count", rd_l, 48384);
      check("l_write_count", wr_l, 126 * 126);
      check("l_pending_writes", q_l.size(), 0);
      pulse_reset();
      @(negedge clk);
      check("l_finish_cleared", l_fin, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
